uart_frame_ctrl: RTL

Sequencer between the UART receiver and the MNIST network's image RAM. It frames the raw byte stream from `uart_rx` into one image packet (sync byte, N_PIXELS pixel bytes, optional checksum), writes the pixels into image RAM, then launches the network and waits for it to finish. It also exports 14-bit good/bad frame counters for the `display` block.

---
 rtl/uart_frame_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_frame_ctrl.sv
// Frames sync + N_PIXELS pixel bytes from uart_rx into image RAM, launches the network, counts good/bad frames.
// Optional checksum byte after the pixels when UART_FRAME_CHECKSUM_EN is defined.
module uart_frame_ctrl #(
    parameter int         N_PIXELS    = 784,
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         TO_W        = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_byte,
    input  logic              net_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              net_start,
    output logic              busy,
    output logic [13:0]       ok_cnt,
    output logic [13:0]       err_cnt,
    output logic [2:0]        state_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK = 3'd2;
`endif
    localparam logic [2:0] ST_RUN   = 3'd3;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIXELS - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [13:0]       CNT_MAX  = 14'd9999;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              pix_last;
    logic              to_expire;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // Counters stop at the display limit instead of wrapping.
    function automatic logic [13:0] sat_inc(input logic [13:0] c);
        return (c == CNT_MAX) ? c : c + 14'd1;
    endfunction

    assign pix_last  = (pix_cnt == LAST_PIX);
    // An arriving byte always beats the timeout terminal cycle.
    assign to_expire = !rx_done_tick && (to_cnt == TO_LAST);
    assign busy      = (state != ST_IDLE);
    assign state_o   = state;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= ST_IDLE;
            pix_cnt   <= '0;
            to_cnt    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            net_start <= 1'b0;
            ok_cnt    <= 14'd0;
            err_cnt   <= 14'd0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            mem_we    <= 1'b0;
            net_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_done_tick && rx_byte == SYNC_BYTE) begin
                        state   <= ST_LOAD;
                        pix_cnt <= '0;
                        to_cnt  <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        csum    <= 8'd0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (rx_done_tick) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= pix_cnt;
                        mem_wdata <= rx_byte;
                        pix_cnt   <= pix_cnt + 1'b1;
                        to_cnt    <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        csum      <= csum + rx_byte;
                        if (pix_last) begin
                            state <= ST_CHECK;
                        end
`else
                        if (pix_last) begin
                            state     <= ST_RUN;
                            net_start <= 1'b1;
                        end
`endif
                    end else if (to_expire) begin
                        err_cnt <= sat_inc(err_cnt);
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
`ifdef UART_FRAME_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_done_tick) begin
                        to_cnt <= '0;
                        if (rx_byte == csum) begin
                            state     <= ST_RUN;
                            net_start <= 1'b1;
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= ST_IDLE;
                        end
                    end else if (to_expire) begin
                        err_cnt <= sat_inc(err_cnt);
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
`endif
                ST_RUN: begin
                    if (net_done) begin
                        ok_cnt <= sat_inc(ok_cnt);
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
